// File: rtl/pong_game_if.sv
// Game-flow bus between the Pong pixel pipeline and the game controller.
// The master drives frame/button/ball events; the slave (controller) returns enables and status.
interface pong_game_if;
    logic       frame_tick;
    logic       start_btn;
    logic       hit;
    logic       miss;
    logic       ball_run;
    logic       ball_reload;
    logic       paddle_run;
    logic [7:0] score;
    logic [1:0] lives;
    logic [2:0] state_code;
    logic [1:0] speed_level;

    modport master (
        output frame_tick, start_btn, hit, miss,
        input  ball_run, ball_reload, paddle_run, score, lives, state_code, speed_level
    );

    modport slave (
        input  frame_tick, start_btn, hit, miss,
        output ball_run, ball_reload, paddle_run, score, lives, state_code, speed_level
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-flow FSM: serve/play/scored/over sequencing, BCD score and lives.
// Optional ball speed-up on repeated hits is enabled by defining PONG_SPEEDUP_EN.
module pong_game_ctrl #(
    parameter int LIVES         = 3,
    parameter int SERVE_FRAMES  = 60,
    parameter int SCORED_FRAMES = 30
`ifdef PONG_SPEEDUP_EN
   ,parameter int SPEEDUP_HITS  = 5
`endif
) (
    input logic        clk,
    input logic        rstn,
    pong_game_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SERVE  = 3'd1,
        S_PLAY   = 3'd2,
        S_SCORED = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    state_t     r_state, w_next;
    logic       r_start_q;
    logic [7:0] r_frm;
    logic       r_reload;
    logic [7:0] r_score;
    logic [1:0] r_lives;
    logic [1:0] r_speed;

    logic w_start_rise, w_new_game, w_hit_ok, w_miss_ok, w_entry;

    assign w_start_rise = bus.start_btn & ~r_start_q;
    // A miss always wins over a simultaneous hit.
    assign w_miss_ok    = (r_state == S_PLAY) & bus.miss;
    assign w_hit_ok     = (r_state == S_PLAY) & bus.hit & ~bus.miss;
    assign w_new_game   = ((r_state == S_IDLE) | (r_state == S_OVER)) & w_start_rise;
    assign w_entry      = (w_next != r_state);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
            r_reload  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_start_q <= bus.start_btn;
            r_reload  <= (w_next == S_SERVE) && (r_state != S_SERVE);
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_OVER: if (w_start_rise) w_next = S_SERVE;
            S_SERVE:  if (bus.frame_tick && r_frm == 8'(SERVE_FRAMES - 1)) w_next = S_PLAY;
            S_PLAY:   if (w_miss_ok) w_next = (r_lives == 2'd1) ? S_OVER : S_SCORED;
            S_SCORED: if (bus.frame_tick && r_frm == 8'(SCORED_FRAMES - 1)) w_next = S_SERVE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Counter restarts on every state change so each phase sees exactly N ticks.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                 r_frm <= 8'd0;
        else if (w_entry)          r_frm <= 8'd0;
        else if (bus.frame_tick && (r_state == S_SERVE || r_state == S_SCORED))
                                   r_frm <= r_frm + 8'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_score <= 8'h00;
            r_lives <= 2'(LIVES);
        end else if (w_new_game) begin
            r_score <= 8'h00;
            r_lives <= 2'(LIVES);
        end else if (w_miss_ok) begin
            r_lives <= r_lives - 2'd1;
        end else if (w_hit_ok && r_score != 8'h99) begin
            if (r_score[3:0] == 4'd9) r_score <= {r_score[7:4] + 4'd1, 4'd0};
            else                      r_score <= {r_score[7:4], r_score[3:0] + 4'd1};
        end
    end

`ifdef PONG_SPEEDUP_EN
    logic [7:0] r_hits;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hits  <= 8'd0;
            r_speed <= 2'd0;
        end else if (w_new_game || w_miss_ok) begin
            r_hits  <= 8'd0;
            r_speed <= 2'd0;
        end else if (w_hit_ok) begin
            if (r_hits == 8'(SPEEDUP_HITS - 1)) begin
                r_hits <= 8'd0;
                if (r_speed != 2'd3) r_speed <= r_speed + 2'd1;
            end else begin
                r_hits <= r_hits + 8'd1;
            end
        end
    end
`else
    assign r_speed = 2'd0;
`endif

    always_comb begin
        bus.ball_run   = 1'b0;
        bus.paddle_run = 1'b0;
        unique case (r_state)
            S_SERVE: bus.paddle_run = 1'b1;
            S_PLAY: begin
                bus.ball_run   = 1'b1;
                bus.paddle_run = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.ball_reload = r_reload;
    assign bus.score       = r_score;
    assign bus.lives       = r_lives;
    assign bus.state_code  = r_state;
    assign bus.speed_level = r_speed;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: inputs change on negedge, outputs checked on the following negedge.
module tb_pong_game_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   ntests = 0;
    int   nfail  = 0;
    int   nrel;

    pong_game_if u_if();

    pong_game_ctrl u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (u_if.slave)
    );

    always #5 clk = ~clk;

`ifdef PONG_SPEEDUP_EN
    localparam logic [1:0] SPD5  = 2'd1;
    localparam logic [1:0] SPD12 = 2'd2;
    localparam logic [1:0] SPD99 = 2'd3;
`else
    localparam logic [1:0] SPD5  = 2'd0;
    localparam logic [1:0] SPD12 = 2'd0;
    localparam logic [1:0] SPD99 = 2'd0;
`endif

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) u_if.frame_tick = 1'b1;
            @(negedge clk) u_if.frame_tick = 1'b0;
        end
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) u_if.hit = 1'b1;
            @(negedge clk) u_if.hit = 1'b0;
        end
    endtask

    task automatic do_miss();
        @(negedge clk) u_if.miss = 1'b1;
        @(negedge clk) u_if.miss = 1'b0;
    endtask

    initial begin
        u_if.frame_tick = 1'b0;
        u_if.start_btn  = 1'b0;
        u_if.hit        = 1'b0;
        u_if.miss       = 1'b0;
        #22 rstn = 1'b1;
        @(negedge clk);
        chk("rst_state", 8'(u_if.state_code), 8'd0);
        chk("rst_score", u_if.score, 8'h00);
        chk("rst_lives", 8'(u_if.lives), 8'd3);
        chk("rst_speed", 8'(u_if.speed_level), 8'd0);
        chk("rst_en", 8'({u_if.ball_run, u_if.paddle_run, u_if.ball_reload}), 8'd0);

        // Held start button: only one rising edge, one reload pulse
        u_if.start_btn = 1'b1;
        nrel = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (u_if.ball_reload) nrel++;
        end
        u_if.start_btn = 1'b0;
        chk("start_reload_cnt", 8'(nrel), 8'd1);
        chk("start_state", 8'(u_if.state_code), 8'd1);
        chk("start_lives", 8'(u_if.lives), 8'd3);
        chk("start_score", u_if.score, 8'h00);
        chk("serve_en", 8'({u_if.ball_run, u_if.paddle_run}), 8'b01);

        ticks(59);
        chk("serve_59", 8'(u_if.state_code), 8'd1);
        ticks(1);
        chk("serve_60", 8'(u_if.state_code), 8'd2);
        chk("play_ball_run", 8'(u_if.ball_run), 8'd1);

        hits(5);
        chk("score_5", u_if.score, 8'h05);
        chk("speed_5", 8'(u_if.speed_level), 8'(SPD5));
        hits(7);
        chk("score_12", u_if.score, 8'h12);
        chk("speed_12", 8'(u_if.speed_level), 8'(SPD12));
        hits(87);
        chk("score_99", u_if.score, 8'h99);
        chk("speed_99", 8'(u_if.speed_level), 8'(SPD99));
        hits(1);
        chk("score_sat", u_if.score, 8'h99);

        // Simultaneous hit and miss: miss wins
        @(negedge clk) begin u_if.hit = 1'b1; u_if.miss = 1'b1; end
        @(negedge clk) begin u_if.hit = 1'b0; u_if.miss = 1'b0; end
        chk("hm_lives", 8'(u_if.lives), 8'd2);
        chk("hm_score", u_if.score, 8'h99);
        chk("hm_state", 8'(u_if.state_code), 8'd3);
        chk("hm_speed", 8'(u_if.speed_level), 8'd0);
        chk("scored_en", 8'({u_if.ball_run, u_if.paddle_run}), 8'd0);

        // Hits and start outside PLAY are ignored
        hits(1);
        chk("scored_hit_ign", u_if.score, 8'h99);
        ticks(29);
        chk("scored_29", 8'(u_if.state_code), 8'd3);
        ticks(1);
        chk("scored_30", 8'(u_if.state_code), 8'd1);
        chk("reserve_reload", 8'(u_if.ball_reload), 8'd1);
        @(negedge clk);
        chk("reload_1clk", 8'(u_if.ball_reload), 8'd0);

        ticks(60);
        chk("play2", 8'(u_if.state_code), 8'd2);
        do_miss();
        chk("miss2_lives", 8'(u_if.lives), 8'd1);
        chk("miss2_state", 8'(u_if.state_code), 8'd3);
        ticks(30);
        ticks(60);
        chk("play3", 8'(u_if.state_code), 8'd2);
        do_miss();
        chk("over_state", 8'(u_if.state_code), 8'd4);
        chk("over_lives", 8'(u_if.lives), 8'd0);
        chk("over_score", u_if.score, 8'h99);
        chk("over_en", 8'({u_if.ball_run, u_if.paddle_run, u_if.ball_reload}), 8'd0);
        ticks(3);
        chk("over_tick_ign", 8'(u_if.state_code), 8'd4);

        @(negedge clk) u_if.start_btn = 1'b1;
        @(negedge clk) u_if.start_btn = 1'b0;
        chk("newgame_state", 8'(u_if.state_code), 8'd1);
        chk("newgame_score", u_if.score, 8'h00);
        chk("newgame_lives", 8'(u_if.lives), 8'd3);
        chk("newgame_reload", 8'(u_if.ball_reload), 8'd1);

        ticks(60);
        hits(3);
        chk("mid_play_score", u_if.score, 8'h03);
        // Asynchronous reset away from any clock edge
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_state", 8'(u_if.state_code), 8'd0);
        chk("async_rst_score", u_if.score, 8'h00);
        chk("async_rst_lives", 8'(u_if.lives), 8'd3);
        #10 rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_state", 8'(u_if.state_code), 8'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
